// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, reset
// defaults, the fetch FSM state type and a few instruction encodings.
`ifndef FETCH_WORD_DEFINED
`define FETCH_WORD_DEFINED
`define WORD 31:0
`endif

package fetch_pkg;

    localparam int WORD_W = 32;

    // Encodings needed to build the canonical bubble instruction (addi x0,x0,0)
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [2:0] F3_ADDI   = 3'b000;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = {12'd0, 5'd0, F3_ADDI, 5'd0, OP_IMM};

    // Fetch register payload: {valid, instr, pc}
    localparam int FREG_W = 1 + 2 * WORD_W;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD,
        S_HALT
    } fetch_state_t;

    // Sequential next PC; wraps naturally at 2^32
    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are forced to word alignment
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory.
interface fetch_if;
    import fetch_pkg::*;

    logic              imemReq;
    logic [WORD_W-1:0] imemAddr;
    logic              imemGnt;
    logic              imemRvalid;
    logic [WORD_W-1:0] imemRdata;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemGnt,
        input  imemRvalid,
        input  imemRdata
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemGnt,
        output imemRvalid,
        output imemRdata
    );
endinterface

// File: rtl/flopenrc.sv
// Register with enable, synchronous clear and synchronous reset.
// Clear and reset both load RESET_VAL; clear wins over enable.
module flopenrc #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: reset, then clear, then enabled load
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding memory request at a time, a
// one-entry skid buffer for responses arriving under stall, redirect and
// halt handling, and the fetch register feeding decode.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [`WORD] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [`WORD] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_if.master      imem,
    input  logic         pcSrcE,
    input  logic [`WORD] pcTargetE,
    input  logic         stallF,
    input  logic         haltE,
    output logic [`WORD] pcD,
    output logic [`WORD] instrD,
    output logic         validD
);

    fetch_state_t state_reg, state_next;
    logic [`WORD] pc_f_reg, pc_f_next;
    logic         skid_valid_reg, skid_valid_next;
    logic [`WORD] skid_pc_reg, skid_pc_next;
    logic [`WORD] skid_instr_reg, skid_instr_next;

    logic              handshake;
    logic              load;
    logic [`WORD]      load_pc;
    logic [`WORD]      load_instr;
    logic              freg_clr;
    logic [FREG_W-1:0] freg_d;
    logic [FREG_W-1:0] freg_q;
    logic [`WORD]      target;

    // Request is suppressed while reset is held so nothing is issued in reset cycles
    assign imem.imemReq  = (state_reg == S_REQ) && !reset;
    assign imem.imemAddr = pc_f_reg;
    assign handshake     = imem.imemReq && imem.imemGnt;
    assign target        = align_word(pcTargetE);

    // Next-state, PC and skid-buffer logic; halt outranks redirect outranks stall
    always_comb begin
        state_next      = state_reg;
        pc_f_next       = pc_f_reg;
        skid_valid_next = skid_valid_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;
        load            = 1'b0;
        load_pc         = pc_f_reg;
        load_instr      = imem.imemRdata;

        if (haltE) begin
            state_next      = S_HALT;
            skid_valid_next = 1'b0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (pcSrcE) begin
                        pc_f_next  = target;
                        // An accepted request still owes a response that must be discarded
                        state_next = handshake ? S_DROP : S_REQ;
                    end else if (handshake) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pcSrcE) begin
                        pc_f_next  = target;
                        state_next = imem.imemRvalid ? S_REQ : S_DROP;
                    end else if (imem.imemRvalid) begin
                        if (stallF) begin
                            skid_valid_next = 1'b1;
                            skid_pc_next    = pc_f_reg;
                            skid_instr_next = imem.imemRdata;
                            state_next      = S_HOLD;
                        end else begin
                            load       = 1'b1;
                            pc_f_next  = pc_plus4(pc_f_reg);
                            state_next = S_REQ;
                        end
                    end
                end
                S_DROP: begin
                    if (pcSrcE) begin
                        pc_f_next = target;
                    end
                    // Leave only once the stale response has been swallowed
                    if (imem.imemRvalid) begin
                        state_next = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (pcSrcE) begin
                        pc_f_next       = target;
                        skid_valid_next = 1'b0;
                        state_next      = S_REQ;
                    end else if (!stallF && skid_valid_reg) begin
                        load            = 1'b1;
                        load_pc         = skid_pc_reg;
                        load_instr      = skid_instr_reg;
                        skid_valid_next = 1'b0;
                        pc_f_next       = pc_plus4(pc_f_reg);
                        state_next      = S_REQ;
                    end
                end
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_REQ;
                end
            endcase
        end
    end

    // Bubble when decode advances without a new instruction; flush on halt/redirect
    always_comb begin
        freg_clr = haltE || pcSrcE || (!stallF && !load);
        freg_d   = {1'b1, load_instr, load_pc};
    end

    // State, PC and skid-buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_REQ;
            pc_f_reg       <= RESET_PC;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_instr_reg <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_f_reg       <= pc_f_next;
            skid_valid_reg <= skid_valid_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
        end
    end

    flopenrc #(
        .WIDTH     (FREG_W),
        .RESET_VAL ({1'b0, NOP_INSTR, 32'h0000_0000})
    ) u_freg (
        .clk   (clk),
        .reset (reset),
        .en    (load),
        .clr   (freg_clr),
        .d     (freg_d),
        .q     (freg_q)
    );

    assign {validD, instrD, pcD} = freg_q;

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instrD value whenever the fetch register is reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imemReq  output  1  instruction-memory request valid.
REQ-006 imemAddr  output  `WORD  request address; always equals pcF.
REQ-007 imemGnt  input  1  memory accepts the request this cycle (imemReq && imemGnt = handshake).
REQ-008 imemRvalid  input  1  read response valid; arrives one or more cycles after the handshake.
REQ-009 imemRdata  input  `WORD  instruction word, valid with imemRvalid.
REQ-010 pcSrcE  input  1  redirect from execute (taken branch or jump).
REQ-011 pcTargetE  input  `WORD  redirect target.
REQ-012 stallF  input  1  decode cannot accept; hold the fetch register.
REQ-013 haltE  input  1  finish instruction reached execute.
REQ-014 pcD, instrD  output  `WORD each  fetch-register outputs to decode.
REQ-015 validD  output  1  fetch-register entry is a real instruction.

Function
REQ-016 The block SHALL keep at most one memory request outstanding.
REQ-017 FSM states: REQ (imemReq=1), WAIT (awaiting response), DROP (awaiting a response to discard), HOLD (response buffered under stall), HALT (imemReq=0).
REQ-018 REQ: on the handshake go to WAIT; with no handshake stay in REQ, keeping imemAddr stable.
REQ-019 WAIT: on imemRvalid with !stallF, load {pcF, imemRdata, 1} into the fetch register, set pcF<=pcF+4, and go to REQ.
REQ-020 WAIT: on imemRvalid with stallF, capture {pcF, imemRdata} in a one-entry skid buffer and go to HOLD; pcF is unchanged.
REQ-021 HOLD: on the first cycle with !stallF, load the skid entry with valid=1, set pcF<=pcF+4, and go to REQ.
REQ-022 A fetch-register load SHALL be visible on pcD/instrD/validD the cycle after the load condition; the best-case handshake-to-validD latency is 2 cycles with a 1-cycle memory.
REQ-023 When no load occurs and !stallF, validD<=0 (bubble); when stallF, all fetch-register outputs hold.
REQ-024 pcSrcE SHALL set pcF<=pcTargetE with bits [1:0] forced to 0, and clear validD the next cycle regardless of stallF.
REQ-025 Redirect transitions:
  - REQ with handshake, or WAIT without imemRvalid -> DROP.
  - REQ without handshake, WAIT with imemRvalid, or HOLD -> REQ, discarding the response or skid entry.
  - DROP -> stay in DROP.
REQ-026 DROP: on imemRvalid, discard the data and go to REQ; the fetch register is never loaded from DROP.
REQ-027 haltE SHALL move the FSM to HALT from any state and clear validD the next cycle; an outstanding response is ignored.
REQ-028 HALT persists until reset.
REQ-029 Priority: reset > haltE > pcSrcE > stallF > normal operation.
REQ-030 pcF+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-031 Without a redirect, fetched PCs SHALL be strictly sequential; no instruction is duplicated or skipped across any stall pattern.

Reset
REQ-032 Reset values: FSM=REQ, pcF=RESET_PC, validD=0, pcD=0, instrD=NOP_INSTR, skid entry invalid.
REQ-033 imemReq SHALL be 0 in every cycle where reset=1; the first request occurs the cycle after reset deasserts.
REQ-034 A reset asserted mid-request SHALL abandon the outstanding request; a stale imemRvalid arriving after reset SHALL be ignored until the block's own first handshake.

Structure
REQ-035 The FSM state enum, RESET_PC, and NOP_INSTR defaults SHALL live in the shared package alongside `WORD and the opcode constants.
REQ-036 The fetch register SHALL be a sub-module flopenrc (enable, synchronous clear, synchronous reset, WIDTH parameter) holding {validD, instrD, pcD}.

Verification
REQ-037 Reset, 1-cycle memory, stallF=0 -> imemAddr 0,4,8 on consecutive handshakes; validD=1 with pcD=0 two cycles after the first handshake.
REQ-038 stallF=1 for 3 cycles while a response for pc=8 arrives -> state HOLD, outputs frozen, imemReq=0; on release, pcD=8 with the correct instr, then pc=12 requested.
REQ-039 pcSrcE=1, pcTargetE=32'h100 while WAIT with 4-cycle memory latency -> DROP, old response discarded, next imemAddr=32'h100, validD=0 in between.
REQ-040 pcSrcE same cycle as imemRvalid -> that instruction never reaches decode; next request at target; target 32'h103 -> imemAddr 32'h100.
REQ-041 haltE=1 while WAIT -> imemReq stays 0, validD=0 indefinitely; reset -> restart at RESET_PC.
REQ-042 RESET_PC=32'hFFFF_FFFC -> second request at 32'h0000_0000.
